mem_region_checker: RTL and testbench
=====================================

# mem_region_checker

Bus initiator that autonomously reads two equal-length word regions from the asynchronous word memory and compares them word by word. It reports a mismatch count per fixed-size line and a running total, giving self-checking benches and in-system tests a hardware comparator instead of hierarchical memory peeks. It drives the memory's `read`/`address` pins and consumes `read_data`. It never writes memory.

## Interface
Parameters:
- `WAIT_CYCLES`, default 3: clock cycles a read is held before data is sampled. Must cover the memory's read latency: 7 ns against a 2.5 ns clock gives 3.
- `LINE_WORDS`, default 16: words per reporting line. Must be a power of two, at least 2.

Ports:
- `clk` input 1: single clock; all state updates on posedge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `start` input 1: begin a check; sampled only in IDLE.
- `base_a` input 32: byte address of region A; bits [1:0] ignored.
- `base_b` input 32: byte address of region B; bits [1:0] ignored.
- `word_count` input 16: number of words to compare.
- `mem_addr` output 32: word-aligned byte address to memory.
- `mem_read` output 1: read strobe to memory.
- `mem_read_data` input 32: memory read data.
- `busy` output 1: high from the cycle after `start` is accepted until `done`.
- `done` output 1: one-cycle pulse at completion.
- `line_valid` output 1: one-cycle pulse when a line result is ready.
- `line_errors` output $clog2(LINE_WORDS+1): mismatches in the reported line.
- `total_errors` output 16: mismatches since the last accepted `start`.

## Operation
- States: IDLE, RD_A, RD_B, CMP, DONE.
- IDLE:
  - `start`=1 with `word_count`≠0: latch bases and count; clear index, line counter and `total_errors`; go to RD_A.
  - `start`=1 with `word_count`=0: go straight to DONE.
- RD_A:
  - `mem_addr` = {`base_a`[31:2],2'b00} + 4·idx, modulo 2^32 (wraps silently).
  - `mem_read`=1 for exactly `WAIT_CYCLES` cycles.
  - On the final posedge, latch `mem_read_data` into data_a; go to RD_B.
- RD_B: identical, using `base_b`, latching data_b; go to CMP.
- CMP (`mem_read`=0):
  - If data_a≠data_b, increment the line counter and `total_errors`.
  - If idx[log2 LINE_WORDS - 1:0] = LINE_WORDS-1, or this is the last word, pulse `line_valid` next cycle with the updated line count, then clear the line counter. A partial final line is reported.
  - If last word, go to DONE; otherwise idx++ and go to RD_A.
- DONE: `done`=1 for one cycle; go to IDLE. `total_errors` holds its value until the next accepted `start`.
- `start` outside IDLE is ignored.
- Reset at any point: IDLE, all outputs 0, in-flight comparison discarded.

## Timing
- Reset values: `mem_addr`=0, `mem_read`=0, `busy`=0, `done`=0, `line_valid`=0, `line_errors`=0, `total_errors`=0.
- Per word: 2·`WAIT_CYCLES`+1 cycles.
- `start` sampled at edge 0 → `done` high during cycle N·(2·`WAIT_CYCLES`+1)+1 after that edge.
- `word_count`=0: `done` in cycle 1.
- `mem_addr` is stable for the whole read window, so the combinational memory output settles before sampling.
- `line_valid` and the final line's count coincide with the DONE transition cycle, never later than `done`.
- All outputs are registered.

## Configuration
- `MEM_CHECK_FIRST_ERR_EN` defined:
  - Adds output `first_err_addr` (32): the region-A byte address of the first mismatch.
  - Adds output `first_err_valid` (1): set on that mismatch.
  - Both cleared on accepted `start` and on reset.
- Undefined: these ports and their registers are absent. All other behaviour is identical.

## Structure
- Package `mem_check_pkg`: state enum, line-counter width function, default `WAIT_CYCLES`/`LINE_WORDS` constants.
- Sub-module `mem_read_port`: wait-state counter plus data latch.
  - Inputs: `req`, `addr`.
  - Outputs: `mem_read`, `mem_addr`, `rdata`, `rvalid` pulse.
  - Instantiated once and reused for both reads.

## Test plan
- Regions at word 32 and word 200 identical, `word_count`=96 → six `line_valid` pulses each with 0, `total_errors`=0, `done` in cycle 96·7+1.
- Same regions, B words 5, 17, 18 corrupted → line counts 1,2,0,0,0,0, `total_errors`=3. With macro: `first_err_addr`=0x94.
- `word_count`=20 → line counts for 16 words then 4 words; partial line reported before `done`.
- `word_count`=0 → `done` in cycle 1, no `mem_read`, `total_errors`=0.
- `base_a`=0xFFFFFFF8, count 4 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4 on A reads.
- Reset asserted mid-RD_B → `mem_read`, `busy` fall immediately; `start` pulsed again during the run is ignored; a new check after reset runs clean.

Source files
------------

// File: rtl/mem_check_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_check_pkg
// Description : Shared types, defaults and helpers for mem_region_checker.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_check_pkg;

  // Default read hold time (7 ns memory behind a 2.5 ns clock) and line size.
  localparam int DEF_WAIT_CYCLES = 3;
  localparam int DEF_LINE_WORDS  = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_CMP  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Width needed to hold a per-line mismatch count of 0..line_words.
  function automatic int line_cnt_width(input int line_words);
    return $clog2(line_words + 1);
  endfunction

  // Word-aligned byte address of word idx in a region (wraps modulo 2^32).
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
    return {base[31:2], 2'b00} + {14'd0, idx, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_read_port.sv
`default_nettype none
// ============================================================================
// Module      : mem_read_port
// Description : Holds a memory read for WAIT_CYCLES clocks at a stable address
//               and latches the read data on the final edge of the window.
//               A req on the final cycle chains a second read seamlessly.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_read_port #(
  parameter int WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [31:0] mem_read_data,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  output logic [31:0] rdata,
  output logic        rvalid
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic          mem_read_q, mem_read_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   rdata_q,    rdata_d;
  logic [CW-1:0] cnt_q,      cnt_d;

  // rvalid marks the last cycle of the read window; data is sampled on the
  // edge that ends it.
  assign rvalid = mem_read_q && (cnt_q == '0);

  // Next-state for the wait counter, address hold and data latch.
  always_comb begin
    mem_read_d = mem_read_q;
    mem_addr_d = mem_addr_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    if (rvalid) begin
      rdata_d    = mem_read_data;
      mem_read_d = 1'b0;
    end else if (mem_read_q) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (req) begin
      mem_read_d = 1'b1;
      mem_addr_d = addr;
      cnt_d      = CW'(WAIT_CYCLES - 1);
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      mem_read_q <= mem_read_d;
      mem_addr_q <= mem_addr_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mem_read = mem_read_q;
  assign mem_addr = mem_addr_q;
  assign rdata    = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mem_region_checker.sv
`default_nettype none
// ============================================================================
// Module      : mem_region_checker
// Description : Reads two equal-length word regions and compares them word by
//               word, reporting per-line and running mismatch counts.
//               Optional macro MEM_CHECK_FIRST_ERR_EN adds first_err_addr and
//               first_err_valid (region-A address of the first mismatch).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_region_checker
  import mem_check_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int LINE_WORDS  = DEF_LINE_WORDS
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [31:0]                      base_a,
  input  logic [31:0]                      base_b,
  input  logic [15:0]                      word_count,
  output logic [31:0]                      mem_addr,
  output logic                             mem_read,
  input  logic [31:0]                      mem_read_data,
  output logic                             busy,
  output logic                             done,
  output logic                             line_valid,
  output logic [$clog2(LINE_WORDS+1)-1:0]  line_errors,
  output logic [15:0]                      total_errors
`ifdef MEM_CHECK_FIRST_ERR_EN
  ,
  output logic [31:0]                      first_err_addr,
  output logic                             first_err_valid
`endif
);

  localparam int LW_BITS = $clog2(LINE_WORDS);
  localparam int LC_W    = line_cnt_width(LINE_WORDS);

  state_e         state_q,       state_d;
  logic [31:0]    base_a_q,      base_a_d;
  logic [31:0]    base_b_q,      base_b_d;
  logic [15:0]    count_q,       count_d;
  logic [15:0]    idx_q,         idx_d;
  logic [31:0]    data_a_q,      data_a_d;
  logic [LC_W-1:0] line_cnt_q,   line_cnt_d;
  logic [LC_W-1:0] line_errors_q, line_errors_d;
  logic           line_valid_q,  line_valid_d;
  logic [15:0]    total_q,       total_d;
  logic           busy_q,        busy_d;
  logic           done_q,        done_d;
`ifdef MEM_CHECK_FIRST_ERR_EN
  logic [31:0]    first_addr_q,  first_addr_d;
  logic           first_valid_q, first_valid_d;
`endif

  logic           req;
  logic [31:0]    req_addr;
  logic [31:0]    rdata;
  logic           rvalid;
  logic           last_word;
  logic           line_end;
  logic           mismatch;
  logic [LC_W-1:0] line_next;

  // One read port serves both regions; RD_A chains straight into RD_B.
  mem_read_port #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_read_port (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .addr          (req_addr),
    .mem_read_data (mem_read_data),
    .mem_read      (mem_read),
    .mem_addr      (mem_addr),
    .rdata         (rdata),
    .rvalid        (rvalid)
  );

  assign last_word = (idx_q == (count_q - 16'd1));
  assign line_end  = &idx_q[LW_BITS-1:0];
  // During CMP the port still holds data_b while data_a sits in data_a_q.
  assign mismatch  = (data_a_q != rdata);
  assign line_next = line_cnt_q + LC_W'(mismatch);

  // Sequencer: issues reads one cycle ahead so the port's registered strobe
  // lines up with the state, and accumulates mismatch counts in CMP.
  always_comb begin
    state_d       = state_q;
    base_a_d      = base_a_q;
    base_b_d      = base_b_q;
    count_d       = count_q;
    idx_d         = idx_q;
    data_a_d      = data_a_q;
    line_cnt_d    = line_cnt_q;
    line_errors_d = line_errors_q;
    line_valid_d  = 1'b0;
    total_d       = total_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    req           = 1'b0;
    req_addr      = word_addr(base_a_q, idx_q);
`ifdef MEM_CHECK_FIRST_ERR_EN
    first_addr_d  = first_addr_q;
    first_valid_d = first_valid_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          total_d    = '0;
          line_cnt_d = '0;
`ifdef MEM_CHECK_FIRST_ERR_EN
          first_addr_d  = '0;
          first_valid_d = 1'b0;
`endif
          if (word_count != 16'd0) begin
            base_a_d = base_a;
            base_b_d = base_b;
            count_d  = word_count;
            idx_d    = '0;
            busy_d   = 1'b1;
            req      = 1'b1;
            req_addr = word_addr(base_a, 16'd0);
            state_d  = ST_RD_A;
          end else begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_RD_A: begin
        if (rvalid) begin
          req      = 1'b1;
          req_addr = word_addr(base_b_q, idx_q);
          state_d  = ST_RD_B;
        end
      end
      ST_RD_B: begin
        if (rvalid) begin
          data_a_d = rdata;
          state_d  = ST_CMP;
        end
      end
      ST_CMP: begin
        if (mismatch) begin
          total_d = total_q + 16'd1;
`ifdef MEM_CHECK_FIRST_ERR_EN
          if (!first_valid_q) begin
            first_addr_d  = word_addr(base_a_q, idx_q);
            first_valid_d = 1'b1;
          end
`endif
        end
        if (line_end || last_word) begin
          line_valid_d  = 1'b1;
          line_errors_d = line_next;
          line_cnt_d    = '0;
        end else begin
          line_cnt_d = line_next;
        end
        if (last_word) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          idx_d    = idx_q + 16'd1;
          req      = 1'b1;
          req_addr = word_addr(base_a_q, idx_q + 16'd1);
          state_d  = ST_RD_A;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered state and outputs, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      base_a_q      <= '0;
      base_b_q      <= '0;
      count_q       <= '0;
      idx_q         <= '0;
      data_a_q      <= '0;
      line_cnt_q    <= '0;
      line_errors_q <= '0;
      line_valid_q  <= 1'b0;
      total_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef MEM_CHECK_FIRST_ERR_EN
      first_addr_q  <= '0;
      first_valid_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      base_a_q      <= base_a_d;
      base_b_q      <= base_b_d;
      count_q       <= count_d;
      idx_q         <= idx_d;
      data_a_q      <= data_a_d;
      line_cnt_q    <= line_cnt_d;
      line_errors_q <= line_errors_d;
      line_valid_q  <= line_valid_d;
      total_q       <= total_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
`ifdef MEM_CHECK_FIRST_ERR_EN
      first_addr_q  <= first_addr_d;
      first_valid_q <= first_valid_d;
`endif
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign line_valid   = line_valid_q;
  assign line_errors  = line_errors_q;
  assign total_errors = total_q;
`ifdef MEM_CHECK_FIRST_ERR_EN
  assign first_err_addr  = first_addr_q;
  assign first_err_valid = first_valid_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_region_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_region_checker
// Description : Directed, table-driven bench for mem_region_checker with a
//               combinational word memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_region_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_a, base_b;
  logic [15:0] word_count;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic [31:0] mem_read_data;
  logic        busy, done, line_valid;
  logic [4:0]  line_errors;
  logic [15:0] total_errors;
`ifdef MEM_CHECK_FIRST_ERR_EN
  logic [31:0] first_err_addr;
  logic        first_err_valid;
`endif

  logic [31:0] mem [0:1023];
  assign mem_read_data = mem[mem_addr[11:2]];

  always #5 clk = ~clk;

  mem_region_checker dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_a        (base_a),
    .base_b        (base_b),
    .word_count    (word_count),
    .mem_addr      (mem_addr),
    .mem_read      (mem_read),
    .mem_read_data (mem_read_data),
    .busy          (busy),
    .done          (done),
    .line_valid    (line_valid),
    .line_errors   (line_errors),
    .total_errors  (total_errors)
`ifdef MEM_CHECK_FIRST_ERR_EN
    ,
    .first_err_addr  (first_err_addr),
    .first_err_valid (first_err_valid)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          n;
    int          c0, c1, c2;      // corrupted B word indices, -1 = unused
    int          exp_lines [6];
    int          exp_nlines;
    int          exp_total;
    int          restart_at;      // cycle at which a stray start is pulsed
  } vec_t;

  localparam int PER_WORD = 7;    // 2*WAIT_CYCLES+1 with WAIT_CYCLES=3

  vec_t vecs [6];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic corrupt(input logic [31:0] b, input int w);
    int idx;
    if (w >= 0) begin
      idx = int'(b[11:2]) + w;
      mem[idx[9:0]] = mem[idx[9:0]] ^ 32'h0000_FFFF;
    end
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    int   got [8];
    int   nl, done_c, last_lv, k;
    bit   seen_read;
    v = vecs[vi];
    corrupt(v.b, v.c0); corrupt(v.b, v.c1); corrupt(v.b, v.c2);
    @(negedge clk);
    base_a = v.a; base_b = v.b; word_count = 16'(v.n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nl = 0; done_c = -1; last_lv = -1; seen_read = 1'b0;
    for (int c = 0; c < 2000 && done_c < 0; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == v.restart_at) begin start = 1'b1; word_count = 16'd5; end
      else start = 1'b0;
      if (mem_read) seen_read = 1'b1;
      k = c / PER_WORD;
      if ((c % PER_WORD) == 0 && k < 4 && k < v.n) begin
        check($sformatf("v%0d_addr_a%0d", vi, k), mem_addr, {v.a[31:2], 2'b00} + 32'(4 * k));
        check($sformatf("v%0d_read_a%0d", vi, k), {31'd0, mem_read}, 32'd1);
      end
      if (c == 0 && v.n != 0) check($sformatf("v%0d_busy", vi), {31'd0, busy}, 32'd1);
      if (line_valid) begin
        if (nl < 8) got[nl] = int'(line_errors);
        nl++;
        last_lv = c;
      end
      if (done) done_c = c;
    end
    start = 1'b0;
    if (done_c < 0) begin
      n_checks++;
      $display("FAIL v%0d_done_timeout: got no done expected done", vi);
    end else begin
      check($sformatf("v%0d_done_cycle", vi), 32'(done_c), 32'(v.n * PER_WORD));
      check($sformatf("v%0d_total", vi), {16'd0, total_errors}, 32'(v.exp_total));
      check($sformatf("v%0d_line_before_done", vi), {31'd0, (last_lv <= done_c)}, 32'd1);
    end
    check($sformatf("v%0d_nlines", vi), 32'(nl), 32'(v.exp_nlines));
    for (int i = 0; i < v.exp_nlines && i < nl && i < 6; i++)
      check($sformatf("v%0d_line%0d", vi, i), 32'(got[i]), 32'(v.exp_lines[i]));
    check($sformatf("v%0d_any_read", vi), {31'd0, seen_read}, {31'd0, (v.n != 0)});
`ifdef MEM_CHECK_FIRST_ERR_EN
    check($sformatf("v%0d_first_valid", vi), {31'd0, first_err_valid}, {31'd0, (v.c0 >= 0)});
    if (v.c0 >= 0)
      check($sformatf("v%0d_first_addr", vi), first_err_addr, {v.a[31:2], 2'b00} + 32'(4 * v.c0));
`endif
    @(posedge clk); #1;
    check($sformatf("v%0d_busy_after", vi), {31'd0, busy}, 32'd0);
    check($sformatf("v%0d_done_pulse", vi), {31'd0, done}, 32'd0);
    corrupt(v.b, v.c0); corrupt(v.b, v.c1); corrupt(v.b, v.c2);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_a = '0; base_b = '0; word_count = '0;
    for (int i = 0; i < 1024; i++) mem[i] = {16'(i), ~16'(i)} ^ 32'h5A5A_0000;
    for (int i = 0; i < 96; i++) mem[200 + i] = mem[32 + i];

    vecs[0] = '{a:32'h80, b:32'h320, n:96, c0:-1, c1:-1, c2:-1,
                exp_lines:'{0,0,0,0,0,0}, exp_nlines:6, exp_total:0, restart_at:10};
    vecs[1] = '{a:32'h80, b:32'h320, n:96, c0:5, c1:17, c2:18,
                exp_lines:'{1,2,0,0,0,0}, exp_nlines:6, exp_total:3, restart_at:-1};
    vecs[2] = '{a:32'h80, b:32'h320, n:20, c0:3, c1:17, c2:-1,
                exp_lines:'{1,1,0,0,0,0}, exp_nlines:2, exp_total:2, restart_at:-1};
    vecs[3] = '{a:32'h80, b:32'h320, n:0, c0:-1, c1:-1, c2:-1,
                exp_lines:'{0,0,0,0,0,0}, exp_nlines:0, exp_total:0, restart_at:-1};
    vecs[4] = '{a:32'hFFFF_FFF8, b:32'hFFFF_FFF8, n:4, c0:-1, c1:-1, c2:-1,
                exp_lines:'{0,0,0,0,0,0}, exp_nlines:1, exp_total:0, restart_at:-1};
    vecs[5] = '{a:32'h80, b:32'h320, n:1, c0:0, c1:-1, c2:-1,
                exp_lines:'{1,0,0,0,0,0}, exp_nlines:1, exp_total:1, restart_at:-1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_line_valid", {31'd0, line_valid}, 32'd0);
    check("rst_line_errors", {27'd0, line_errors}, 32'd0);
    check("rst_total", {16'd0, total_errors}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int vi = 0; vi < 6; vi++) run_vec(vi);

    // Asynchronous reset in the middle of the first B read.
    @(negedge clk);
    base_a = 32'h80; base_b = 32'h320; word_count = 16'd96; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    check("mid_read_active", {31'd0, mem_read}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_vec(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
